// File: rtl/snake_pkg.sv
// Shared playfield defaults, coordinate type and food spawner state encoding.
package snake_pkg;

  localparam int GRID_W_DEF    = 40;
  localparam int GRID_H_DEF    = 30;
  localparam int COORD_W_DEF   = 8;
  localparam int MAX_TRIES_DEF = 16;

  typedef logic [COORD_W_DEF-1:0] coord_t;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PICK_X    = 3'd1,
    ST_PICK_Y    = 3'd2,
    ST_CHECK     = 3'd3,
    ST_WAIT      = 3'd4,
    ST_SCAN_CHK  = 3'd5,
    ST_SCAN_WAIT = 3'd6
  } spawner_state_e;

endpackage

// File: rtl/range_sampler.sv
// Combinational rejection test: accepts a raw random value only when it is
// below the limit, so accepted values are uniform with no modulo bias.
module range_sampler #(
  parameter int COORD_W = 8
) (
  input  logic [COORD_W-1:0] rand_in,
  input  logic [COORD_W:0]   limit,
  output logic               accept,
  output logic [COORD_W-1:0] value
);

  // One extra bit on the limit lets a full 2**COORD_W range be expressed.
  assign accept = ({1'b0, rand_in} < limit);
  assign value  = rand_in;

endmodule

// File: rtl/food_spawner.sv
// Picks a free playfield cell for the next food item: rejection-sampled random
// candidates first, then a row-major scan once MAX_TRIES candidates were occupied.
module food_spawner
  import snake_pkg::*;
#(
  parameter int GRID_W    = GRID_W_DEF,
  parameter int GRID_H    = GRID_H_DEF,
  parameter int COORD_W   = COORD_W_DEF,
  parameter int MAX_TRIES = MAX_TRIES_DEF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               spawn_req,
  input  logic [COORD_W-1:0] rand_in,
  output logic               occ_rd,
  output logic [COORD_W-1:0] occ_x,
  output logic [COORD_W-1:0] occ_y,
  input  logic               occ_hit,
  output logic [COORD_W-1:0] food_x,
  output logic [COORD_W-1:0] food_y,
  output logic               food_valid,
  output logic               busy,
  output logic               spawn_fail
);

  localparam int CELLS = GRID_W * GRID_H;
  localparam int CL_W  = $clog2(CELLS + 1);
  localparam int TR_W  = $clog2(MAX_TRIES + 1);

  localparam logic [COORD_W:0]   LIM_X  = GRID_W[COORD_W:0];
  localparam logic [COORD_W:0]   LIM_Y  = GRID_H[COORD_W:0];
  localparam logic [COORD_W-1:0] X_LAST = COORD_W'(GRID_W - 1);
  localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(GRID_H - 1);

  spawner_state_e state, state_n;

  logic [COORD_W-1:0] cx, cy, sx, sy;
  logic [TR_W-1:0]    tries;
  logic [TR_W:0]      tries_inc;
  logic [CL_W-1:0]    cells_left;
  logic               last_try;
  logic               x_ok, y_ok;
  logic [COORD_W-1:0] x_val, y_val;

  range_sampler #(.COORD_W(COORD_W)) u_x_sampler (
    .rand_in (rand_in),
    .limit   (LIM_X),
    .accept  (x_ok),
    .value   (x_val)
  );

  range_sampler #(.COORD_W(COORD_W)) u_y_sampler (
    .rand_in (rand_in),
    .limit   (LIM_Y),
    .accept  (y_ok),
    .value   (y_val)
  );

  assign tries_inc = {1'b0, tries} + (TR_W+1)'(1);
  assign last_try  = (tries_inc == (TR_W+1)'(MAX_TRIES));

  // Request handshake: spawn_req is taken only while busy=0 (IDLE); a request
  // seen while busy=1 is dropped. The result is food_valid (held) or spawn_fail (pulse).
  assign busy = (state != ST_IDLE);

  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    occ_rd  = 1'b0;
    occ_x   = '0;
    occ_y   = '0;
    case (state)
      ST_IDLE:   if (spawn_req) state_n = ST_PICK_X;
      ST_PICK_X: if (x_ok) state_n = ST_PICK_Y;
      ST_PICK_Y: if (y_ok) state_n = ST_CHECK;
      ST_CHECK: begin
        occ_rd  = 1'b1;
        occ_x   = cx;
        occ_y   = cy;
        state_n = ST_WAIT;
      end
      ST_WAIT: begin
        if (!occ_hit)     state_n = ST_IDLE;
        else if (last_try) state_n = ST_SCAN_CHK;
        else              state_n = ST_PICK_X;
      end
      ST_SCAN_CHK: begin
        occ_rd  = 1'b1;
        occ_x   = sx;
        occ_y   = sy;
        state_n = ST_SCAN_WAIT;
      end
      ST_SCAN_WAIT: begin
        if (!occ_hit || cells_left == CL_W'(1)) state_n = ST_IDLE;
        else                                    state_n = ST_SCAN_CHK;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cx         <= '0;
      cy         <= '0;
      sx         <= '0;
      sy         <= '0;
      tries      <= '0;
      cells_left <= '0;
      food_x     <= '0;
      food_y     <= '0;
      food_valid <= 1'b0;
      spawn_fail <= 1'b0;
    end else begin
      spawn_fail <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (spawn_req) begin
            food_valid <= 1'b0;
            tries      <= '0;
          end
        end
        ST_PICK_X: if (x_ok) cx <= x_val;
        ST_PICK_Y: if (y_ok) cy <= y_val;
        ST_WAIT: begin
          if (!occ_hit) begin
            food_x     <= cx;
            food_y     <= cy;
            food_valid <= 1'b1;
          end else begin
            tries <= tries_inc[TR_W-1:0];
            if (last_try) begin
              // Scan starts on the last rejected candidate, so it is looked up once more.
              sx         <= cx;
              sy         <= cy;
              cells_left <= CL_W'(CELLS);
            end
          end
        end
        ST_SCAN_WAIT: begin
          if (!occ_hit) begin
            food_x     <= sx;
            food_y     <= sy;
            food_valid <= 1'b1;
          end else begin
            cells_left <= cells_left - CL_W'(1);
            if (cells_left == CL_W'(1)) spawn_fail <= 1'b1;
            if (sx == X_LAST) begin
              sx <= '0;
              sy <= (sy == Y_LAST) ? '0 : sy + COORD_W'(1);
            end else begin
              sx <= sx + COORD_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_food_spawner.sv
// Bench for food_spawner: directed scenarios plus random boards and random
// streams, predicted by a cell-index model of the spawn rules.
module tb_food_spawner;
  import snake_pkg::*;

  localparam int GW  = 40;
  localparam int GH  = 30;
  localparam int MT  = 16;
  localparam int N   = GW * GH;
  localparam int RL  = 4000;

  logic        clock;
  logic        reset;
  logic        spawn_req;
  logic [7:0]  rand_in;
  logic        occ_rd;
  logic [7:0]  occ_x, occ_y;
  logic        occ_hit;
  logic [7:0]  food_x, food_y;
  logic        food_valid;
  logic        busy;
  logic        spawn_fail;

  food_spawner #(.GRID_W(GW), .GRID_H(GH), .COORD_W(8), .MAX_TRIES(MT)) dut (
    .clock      (clock),
    .reset      (reset),
    .spawn_req  (spawn_req),
    .rand_in    (rand_in),
    .occ_rd     (occ_rd),
    .occ_x      (occ_x),
    .occ_y      (occ_y),
    .occ_hit    (occ_hit),
    .food_x     (food_x),
    .food_y     (food_y),
    .food_valid (food_valid),
    .busy       (busy),
    .spawn_fail (spawn_fail)
  );

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] exp_q[$];
  logic [15:0] obs_q[$];
  bit          board[0:N-1];
  logic [7:0]  r[0:RL-1];
  logic        pend_v, pend_b;
  logic        model_fv;
  coord_t      model_fx, model_fy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: answer last cycle's lookup, log lookups, apply inputs for the next edge.
  task automatic tick(input logic req, input logic [7:0] rv, input logic rst);
    @(negedge clock);
    occ_hit = pend_v ? pend_b : 1'($urandom_range(0, 1));
    pend_v  = occ_rd;
    if (occ_rd) begin
      obs_q.push_back({occ_x, occ_y});
      pend_b = (occ_x < GW && occ_y < GH) ? board[int'(occ_y) * GW + int'(occ_x)] : 1'b1;
    end
    spawn_req = req;
    rand_in   = rv;
    reset     = rst;
  endtask

  task automatic fill_rand();
    for (int i = 0; i < RL; i++)
      r[i] = $urandom_range(0, 1) ? 8'($urandom_range(0, 63)) : 8'($urandom_range(0, 255));
  endtask

  task automatic fill_board(input int pct);
    for (int i = 0; i < N; i++) board[i] = ($urandom_range(0, 99) < pct);
  endtask

  task automatic do_spawn(input string tag);
    int     t, tries, done_tick, bad, fails_seen, mm, idx;
    logic   exp_fail, finished;
    coord_t cx, cy, fx, fy;
    exp_q.delete();
    obs_q.delete();
    // Reference: walk the random stream by the spawn rules, tick by tick.
    t = 1; tries = 0; finished = 0; exp_fail = 0; fx = 0; fy = 0; done_tick = 0;
    while (!finished) begin
      while (t < RL - 10 && r[t] >= GW) t++;
      cx = r[t]; t++;
      while (t < RL - 10 && r[t] >= GH) t++;
      cy = r[t]; t++;
      exp_q.push_back({cx, cy});
      if (!board[int'(cy) * GW + int'(cx)]) begin
        fx = cx; fy = cy; done_tick = t + 2; finished = 1;
      end else begin
        tries++;
        t += 2;
        if (tries == MT) begin
          exp_fail = 1;
          done_tick = t + 2 * N;
          for (int k = 0; k < N; k++) begin
            idx = (int'(cy) * GW + int'(cx) + k) % N;
            exp_q.push_back({8'(idx % GW), 8'(idx / GW)});
            if (!board[idx]) begin
              fx = 8'(idx % GW); fy = 8'(idx / GW);
              exp_fail = 0; done_tick = t + 2 * k + 2;
              break;
            end
          end
          finished = 1;
        end
      end
    end
    bad = 0; fails_seen = 0;
    for (int k = 0; k <= done_tick; k++) begin
      tick((k == 0) ? 1'b1 : ((k < done_tick) ? 1'($urandom_range(0, 3) == 0) : 1'b0),
           r[k], 1'b0);
      if (k == 0) begin
        chk({tag, "/held_valid"}, food_valid, model_fv);
        if (model_fv) chk({tag, "/held_food"}, {food_x, food_y}, {model_fx, model_fy});
      end else if (k < done_tick) begin
        if (busy !== 1'b1 || food_valid !== 1'b0) bad++;
      end
      if (spawn_fail === 1'b1) fails_seen++;
    end
    chk({tag, "/busy_during"}, bad, 0);
    chk({tag, "/busy_done"}, busy, 0);
    chk({tag, "/food_valid"}, food_valid, !exp_fail);
    chk({tag, "/fail_pulses"}, fails_seen, exp_fail);
    if (!exp_fail) chk({tag, "/food_xy"}, {food_x, food_y}, {fx, fy});
    tick(1'b0, r[done_tick + 1], 1'b0);
    chk({tag, "/fail_cleared"}, spawn_fail, 0);
    chk({tag, "/valid_held"}, food_valid, !exp_fail);
    chk({tag, "/n_lookups"}, obs_q.size(), exp_q.size());
    mm = 0;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      if (obs_q[i] !== exp_q[i]) mm++;
    chk({tag, "/lookup_mismatches"}, mm, 0);
    model_fv = !exp_fail;
    if (!exp_fail) begin model_fx = fx; model_fy = fy; end
  endtask

  initial begin
    int bad, pos, pct;
    reset = 1'b1; spawn_req = 1'b0; rand_in = '0; occ_hit = 1'b0;
    pend_v = 1'b0; pend_b = 1'b0; model_fv = 1'b0; model_fx = '0; model_fy = '0;

    // 1: reset, then idle with random inputs
    tick(1'b0, 8'd0, 1'b1);
    tick(1'b1, 8'd0, 1'b1);
    tick(1'b0, 8'd0, 1'b0);
    chk("reset/outputs", {occ_rd, occ_x, occ_y, food_x, food_y, food_valid, busy, spawn_fail}, 0);
    obs_q.delete();
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1'b0, 8'($urandom_range(0, 255)), 1'b0);
      if (busy !== 1'b0 || food_valid !== 1'b0 || spawn_fail !== 1'b0) bad++;
    end
    chk("idle/quiet", bad, 0);
    chk("idle/no_occ_rd", obs_q.size(), 0);

    // 2: happy path
    for (int i = 0; i < N; i++) board[i] = 1'b0;
    fill_rand(); r[1] = 8'd5; r[2] = 8'd7;
    do_spawn("happy");

    // 3: out-of-range values are resampled
    fill_rand(); r[1] = 8'd45; r[2] = 8'd200; r[3] = 8'd12; r[4] = 8'd29;
    do_spawn("reject");

    // 4: fallback scan from (39,29) wraps to (3,0)
    for (int i = 0; i < N; i++) board[i] = 1'b0;
    board[0] = 1'b1; board[1] = 1'b1; board[2] = 1'b1; board[N-1] = 1'b1;
    for (int i = 0; i < RL; i++) r[i] = 8'd255;
    pos = 1;
    for (int j = 0; j < MT; j++) begin
      r[pos]     = (j < MT - 1) ? 8'd0 : 8'd39;
      r[pos + 1] = (j < MT - 1) ? 8'd0 : 8'd29;
      pos += 4;
    end
    do_spawn("fallback");

    // 5: full board
    for (int i = 0; i < N; i++) board[i] = 1'b1;
    fill_rand();
    do_spawn("full");

    // 6: reset while waiting on a free cell
    for (int i = 0; i < N; i++) board[i] = 1'b0;
    tick(1'b1, 8'd255, 1'b0);
    tick(1'b0, 8'd5, 1'b0);
    tick(1'b0, 8'd7, 1'b0);
    tick(1'b0, 8'd255, 1'b0);
    chk("rst_wait/occ_rd", {occ_rd, occ_x, occ_y}, {1'b1, 8'd5, 8'd7});
    tick(1'b0, 8'd255, 1'b1);
    chk("rst_wait/busy_in_wait", busy, 1);
    tick(1'b0, 8'd255, 1'b0);
    chk("rst_wait/after", {food_valid, busy, spawn_fail, occ_rd, food_x, food_y}, 0);
    tick(1'b1, 8'd3, 1'b1);
    tick(1'b0, 8'd3, 1'b0);
    chk("rst_wins/idle", busy, 0);
    model_fv = 1'b0;

    // Random boards and streams
    for (int n = 0; n < 24; n++) begin
      case ($urandom_range(0, 3))
        0: pct = 0;
        1: pct = 30;
        2: pct = 80;
        default: pct = 97;
      endcase
      fill_board(pct);
      fill_rand();
      do_spawn($sformatf("rand%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
